// File: rtl/inv_arbiter.sv
// inv_arbiter: two-requester round-robin arbiter feeding a shared inverter
// result register with valid/ready output handshake. Rev 1.0
`default_nettype none

module inv_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  input  logic             resp_ready,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   slot_free;
  logic   grant0;
  logic   grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants are masked during reset so no handshake completes while cleared.
  always_comb begin
    state_nxt = state;
    slot_free = (state == IDLE) || resp_ready;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (slot_free && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    if (grant0 || grant1) begin
      state_nxt = FULL;
    end else if (state == FULL && resp_ready) begin
      state_nxt = IDLE;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data  <= '0;
      resp_id    <= 1'b0;
      last_grant <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      if (grant0) begin
        resp_data  <= ~req0_data;
        resp_id    <= 1'b0;
        last_grant <= 1'b0;
        cnt0       <= cnt0 + 1'b1;
      end else if (grant1) begin
        resp_data  <= ~req1_data;
        resp_id    <= 1'b1;
        last_grant <= 1'b1;
        cnt1       <= cnt1 + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inv_arbiter.sv
// tb_inv_arbiter: scoreboard bench for inv_arbiter; expected results are
// queued on each accepted operand and compared as the consumer takes them.
`default_nettype none

module tb_inv_arbiter;

  localparam int WIDTH = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_id;
  logic             resp_ready;
  logic [CNTW-1:0]  cnt0, cnt1;

  inv_arbiter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit              m_full;
  bit              m_last;
  logic [CNTW-1:0] m_cnt0, m_cnt1;
  logic [WIDTH:0]  q[$];
  bit              free, g0, g1;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_valid", resp_valid, 0);
      check("rst_data", resp_data, 0);
      check("rst_id", resp_id, 0);
      check("rst_cnt0", cnt0, 0);
      check("rst_cnt1", cnt1, 0);
      m_full = 0;
      m_last = 1;
      m_cnt0 = '0;
      m_cnt1 = '0;
      q.delete();
    end else begin
      free = !m_full || resp_ready;
      g0   = free && req0_valid && (!req1_valid || m_last);
      g1   = free && req1_valid && (!req0_valid || !m_last);
      check("ready0", req0_ready, g0);
      check("ready1", req1_ready, g1);
      check("resp_valid", resp_valid, m_full);
      check("cnt0", cnt0, m_cnt0);
      check("cnt1", cnt1, m_cnt1);
      if (m_full) begin
        if (q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          check("resp", {resp_id, resp_data}, q[0]);
          if (resp_ready) void'(q.pop_front());
        end
      end
      if (g0) begin
        q.push_back({1'b0, ~req0_data});
        m_cnt0 = m_cnt0 + 1'b1;
        m_last = 0;
      end
      if (g1) begin
        q.push_back({1'b1, ~req1_data});
        m_cnt1 = m_cnt1 + 1'b1;
        m_last = 1;
      end
      if (g0 || g1) m_full = 1;
      else if (resp_ready) m_full = 0;
    end
  end

  task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic rr);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    resp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;

    // Idle pop from reset
    drive(0, 0, 0, 0, 1);
    repeat (3) step();
    check("idle_valid", resp_valid, 0);
    check("idle_cnt0", cnt0, 0);
    check("idle_cnt1", cnt1, 0);

    // Single request
    drive(1, 4'b0001, 0, 0, 1);
    step();
    check("single_valid", resp_valid, 1);
    check("single_data", resp_data, 4'b1110);
    check("single_id", resp_id, 0);
    check("single_cnt0", cnt0, 1);
    drive(0, 0, 0, 0, 1);
    step();

    // Contention from reset: 0,1,0,1
    pulse_reset();
    drive(1, 4'b0000, 1, 4'b1010, 1);
    step();
    check("cont_first_id", resp_id, 0);
    check("cont_first_data", resp_data, 4'b1111);
    repeat (3) step();
    check("cont_last_id", resp_id, 1);
    check("cont_last_data", resp_data, 4'b0101);
    drive(0, 0, 0, 0, 1);
    step();
    check("cont_cnt0", cnt0, 2);
    check("cont_cnt1", cnt1, 2);

    // Backpressure
    drive(1, 4'b0011, 1, 4'b0110, 1);
    step();
    drive(1, 4'b0011, 1, 4'b0110, 0);
    repeat (4) step();
    check("bp_valid", resp_valid, 1);
    drive(1, 4'b0011, 1, 4'b0110, 1);
    step();
    drive(0, 0, 0, 0, 1);
    step();

    // Counter wrap on requester 1
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 1, 4'($urandom), 1);
      step();
    end
    drive(0, 0, 0, 0, 1);
    step();
    check("wrap_cnt1", cnt1, 0);
    check("wrap_cnt0", cnt0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) != 0));
      step();
    end

    // Reset while FULL
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 1, 4'b1010, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check("pre_rst_data", resp_data, 4'b0101);
    check("pre_rst_valid", resp_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", resp_valid, 0);
    check("async_data", resp_data, 0);
    step();
    drive(1, 4'b0100, 1, 4'b1000, 1);
    reset = 1'b0;
    step();
    check("post_rst_id", resp_id, 0);
    check("post_rst_data", resp_data, 4'b1011);
    drive(0, 0, 0, 0, 1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
